// File: rtl/atm_pkg.sv
// Shared constants and FSM encoding for the ATM header checker.
// Cell geometry, HEC polynomial/coset and the idle-cell header pattern.
package atm_pkg;

    localparam int ATM_CELL_BYTES = 53;
    localparam int ATM_HDR_BYTES  = 5;
    localparam int ATM_PAY_BYTES  = 48;

    localparam logic [7:0]  HEC_POLY  = 8'h07;
    localparam logic [7:0]  HEC_COSET = 8'h55;
    localparam logic [31:0] IDLE_HDR  = 32'h0000_0001;

    typedef enum logic [2:0] {
        ST_HUNT = 3'd0,
        ST_HDR  = 3'd1,
        ST_HEC  = 3'd2,
        ST_PAY  = 3'd3,
        ST_DISC = 3'd4
    } atm_state_e;

endpackage

// File: rtl/atm_header_checker_if.sv
// Byte-stream bundle: cell bytes in, forwarded payload bytes out.
interface atm_header_checker_if;

    logic [7:0] data_in;
    logic       valid_in;
    logic       sop_in;
    logic [7:0] pay_out;
    logic       pay_valid;
    logic       pay_sop;
    logic       pay_eop;

    modport master (
        output data_in, valid_in, sop_in,
        input  pay_out, pay_valid, pay_sop, pay_eop
    );

    modport slave (
        input  data_in, valid_in, sop_in,
        output pay_out, pay_valid, pay_sop, pay_eop
    );

endinterface

// File: rtl/atm_hec_crc8.sv
// One-byte-per-cycle CRC-8 (x^8+x^2+x+1), MSB first, used for the ATM HEC.
module atm_hec_crc8
    import atm_pkg::*;
(
    input  logic [7:0] crc_in,
    input  logic [7:0] data,
    output logic [7:0] crc_out
);

    logic [7:0] c_s;

    // Eight serial shift steps unrolled into one combinational update.
    always_comb begin
        c_s = crc_in ^ data;
        for (int i = 0; i < 8; i++) begin
            c_s = {c_s[6:0], 1'b0} ^ (c_s[7] ? HEC_POLY : 8'h00);
        end
        crc_out = c_s;
    end

endmodule

// File: rtl/atm_header_checker.sv
// ATM cell header checker: HEC verification, UNI field extraction,
// errored/idle cell filtering, payload forwarding and saturating statistics.
module atm_header_checker
    import atm_pkg::*;
#(
    parameter bit DROP_ERR  = 1'b1,
    parameter bit DROP_IDLE = 1'b1,
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    atm_header_checker_if.slave  cell_if,
    output logic [3:0]           gfc,
    output logic [7:0]           vpi,
    output logic [15:0]          vci,
    output logic [2:0]           pt,
    output logic                 clp,
    output logic                 hdr_valid,
    output logic                 hec_err,
    output logic [CNT_W-1:0]     cnt_good,
    output logic [CNT_W-1:0]     cnt_err,
    output logic [CNT_W-1:0]     cnt_idle,
    output logic [CNT_W-1:0]     cnt_runt
);

    localparam logic [5:0] HDR_LAST_BYTE = 6'(ATM_HDR_BYTES - 2);
    localparam logic [5:0] PAY_FIRST     = 6'(ATM_HDR_BYTES);
    localparam logic [5:0] CELL_LAST     = 6'(ATM_CELL_BYTES - 1);

    atm_state_e  state_r;
    logic [5:0]  cnt_r;
    logic [7:0]  crc_r;
    logic [31:0] hdr_r;
    logic [7:0]  crc_in_s;
    logic [7:0]  crc_next_s;
    logic        hec_err_s;
    logic        is_idle_s;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    // A start-of-cell byte always restarts the CRC from zero.
    always_comb begin
        if ((state_r == ST_HUNT) || cell_if.sop_in) begin
            crc_in_s = 8'h00;
        end else begin
            crc_in_s = crc_r;
        end
        hec_err_s = (cell_if.data_in != (crc_r ^ HEC_COSET));
        is_idle_s = (hdr_r == IDLE_HDR) && !hec_err_s;
    end

    atm_hec_crc8 u_crc (
        .crc_in  (crc_in_s),
        .data    (cell_if.data_in),
        .crc_out (crc_next_s)
    );

    // Cell FSM with registered header fields, payload stream and counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r           <= ST_HUNT;
            cnt_r             <= 6'd0;
            crc_r             <= 8'h00;
            hdr_r             <= 32'h0;
            gfc               <= 4'h0;
            vpi               <= 8'h00;
            vci               <= 16'h0000;
            pt                <= 3'd0;
            clp               <= 1'b0;
            hdr_valid         <= 1'b0;
            hec_err           <= 1'b0;
            cell_if.pay_out   <= 8'h00;
            cell_if.pay_valid <= 1'b0;
            cell_if.pay_sop   <= 1'b0;
            cell_if.pay_eop   <= 1'b0;
            cnt_good          <= '0;
            cnt_err           <= '0;
            cnt_idle          <= '0;
            cnt_runt          <= '0;
        end else begin
            hdr_valid         <= 1'b0;
            cell_if.pay_valid <= 1'b0;
            cell_if.pay_sop   <= 1'b0;
            cell_if.pay_eop   <= 1'b0;
            if (cell_if.valid_in) begin
                if (cell_if.sop_in) begin
                    // An sop outside HUNT truncates the cell in flight; eop is never sent for it.
                    if (state_r != ST_HUNT) begin
                        cnt_runt <= sat_inc(cnt_runt);
                    end
                    state_r <= ST_HDR;
                    crc_r   <= crc_next_s;
                    hdr_r   <= {24'h000000, cell_if.data_in};
                    cnt_r   <= 6'd1;
                end else begin
                    case (state_r)
                        ST_HUNT: begin
                            cnt_r <= 6'd0;
                        end
                        ST_HDR: begin
                            hdr_r <= {hdr_r[23:0], cell_if.data_in};
                            crc_r <= crc_next_s;
                            cnt_r <= cnt_r + 6'd1;
                            if (cnt_r == HDR_LAST_BYTE) begin
                                state_r <= ST_HEC;
                            end
                        end
                        ST_HEC: begin
                            hdr_valid <= 1'b1;
                            hec_err   <= hec_err_s;
                            gfc       <= hdr_r[31:28];
                            vpi       <= hdr_r[27:20];
                            vci       <= hdr_r[19:4];
                            pt        <= hdr_r[3:1];
                            clp       <= hdr_r[0];
                            cnt_r     <= PAY_FIRST;
                            if (hec_err_s) begin
                                cnt_err <= sat_inc(cnt_err);
                                state_r <= DROP_ERR ? ST_DISC : ST_PAY;
                            end else if (is_idle_s) begin
                                cnt_idle <= sat_inc(cnt_idle);
                                state_r  <= DROP_IDLE ? ST_DISC : ST_PAY;
                            end else begin
                                cnt_good <= sat_inc(cnt_good);
                                state_r  <= ST_PAY;
                            end
                        end
                        ST_PAY, ST_DISC: begin
                            if (state_r == ST_PAY) begin
                                cell_if.pay_out   <= cell_if.data_in;
                                cell_if.pay_valid <= 1'b1;
                                cell_if.pay_sop   <= (cnt_r == PAY_FIRST);
                                cell_if.pay_eop   <= (cnt_r == CELL_LAST);
                            end
                            if (cnt_r == CELL_LAST) begin
                                state_r <= ST_HUNT;
                                cnt_r   <= 6'd0;
                            end else begin
                                cnt_r <= cnt_r + 6'd1;
                            end
                        end
                        default: begin
                            state_r <= ST_HUNT;
                            cnt_r   <= 6'd0;
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_atm_header_checker.sv
// Directed bench for atm_header_checker: three configurations driven in lockstep.
module tb_atm_header_checker;
    import atm_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    atm_header_checker_if ifa ();
    atm_header_checker_if ifb ();
    atm_header_checker_if ifc ();

    logic [3:0]  gfc [3];
    logic [7:0]  vpi [3];
    logic [15:0] vci [3];
    logic [2:0]  pt  [3];
    logic        clp [3];
    logic        hv  [3];
    logic        he  [3];
    logic [15:0] cg  [2];
    logic [15:0] ce  [2];
    logic [15:0] ci  [2];
    logic [15:0] cr  [2];
    logic [1:0]  cg_c, ce_c, ci_c, cr_c;

    atm_header_checker dut_a (
        .clk(clk), .rst_n(rst_n), .cell_if(ifa.slave),
        .gfc(gfc[0]), .vpi(vpi[0]), .vci(vci[0]), .pt(pt[0]), .clp(clp[0]),
        .hdr_valid(hv[0]), .hec_err(he[0]),
        .cnt_good(cg[0]), .cnt_err(ce[0]), .cnt_idle(ci[0]), .cnt_runt(cr[0])
    );

    atm_header_checker #(.DROP_ERR(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .cell_if(ifb.slave),
        .gfc(gfc[1]), .vpi(vpi[1]), .vci(vci[1]), .pt(pt[1]), .clp(clp[1]),
        .hdr_valid(hv[1]), .hec_err(he[1]),
        .cnt_good(cg[1]), .cnt_err(ce[1]), .cnt_idle(ci[1]), .cnt_runt(cr[1])
    );

    atm_header_checker #(.CNT_W(2)) dut_c (
        .clk(clk), .rst_n(rst_n), .cell_if(ifc.slave),
        .gfc(gfc[2]), .vpi(vpi[2]), .vci(vci[2]), .pt(pt[2]), .clp(clp[2]),
        .hdr_valid(hv[2]), .hec_err(he[2]),
        .cnt_good(cg_c), .cnt_err(ce_c), .cnt_idle(ci_c), .cnt_runt(cr_c)
    );

    logic [7:0] po [3];
    logic       pv [3];
    logic       ps [3];
    logic       pe [3];
    assign po[0] = ifa.pay_out;  assign pv[0] = ifa.pay_valid;
    assign ps[0] = ifa.pay_sop;  assign pe[0] = ifa.pay_eop;
    assign po[1] = ifb.pay_out;  assign pv[1] = ifb.pay_valid;
    assign ps[1] = ifb.pay_sop;  assign pe[1] = ifb.pay_eop;
    assign po[2] = ifc.pay_out;  assign pv[2] = ifc.pay_valid;
    assign ps[2] = ifc.pay_sop;  assign pe[2] = ifc.pay_eop;

    // Monitor: payload k of every cell must be k+1; header fields latched on hdr_valid.
    int n_pay [3] = '{0, 0, 0};
    int n_sop [3] = '{0, 0, 0};
    int n_eop [3] = '{0, 0, 0};
    int n_hdr [3] = '{0, 0, 0};
    int n_bad [3] = '{0, 0, 0};
    int idx   [3] = '{0, 0, 0};
    logic [3:0]  l_gfc;
    logic [7:0]  l_vpi;
    logic [15:0] l_vci;
    logic [2:0]  l_pt;
    logic        l_clp;
    logic        l_hec [3];

    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (pv[d]) begin
                if (ps[d]) idx[d] = 0;
                if (po[d] !== 8'(idx[d] + 1)) n_bad[d] = n_bad[d] + 1;
                idx[d]   = idx[d] + 1;
                n_pay[d] = n_pay[d] + 1;
                if (ps[d]) n_sop[d] = n_sop[d] + 1;
                if (pe[d]) n_eop[d] = n_eop[d] + 1;
            end
            if (hv[d]) begin
                n_hdr[d] = n_hdr[d] + 1;
                l_hec[d] = he[d];
            end
        end
        if (hv[0]) begin
            l_gfc = gfc[0]; l_vpi = vpi[0]; l_vci = vci[0]; l_pt = pt[0]; l_clp = clp[0];
        end
    end

    int n_checks = 0;
    int n_fail   = 0;
    bit gap_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [7:0] d, input logic v, input logic s);
        ifa.data_in = d; ifa.valid_in = v; ifa.sop_in = s;
        ifb.data_in = d; ifb.valid_in = v; ifb.sop_in = s;
        ifc.data_in = d; ifc.valid_in = v; ifc.sop_in = s;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            drive(8'h00, 1'b0, 1'b0);
        end
    endtask

    // Gap cycles carry junk data and a stray sop that must be ignored.
    task automatic send_byte(input logic [7:0] d, input logic s);
        if (gap_en && ($urandom_range(0, 2) == 0)) begin
            for (int g = 0; g < int'($urandom_range(1, 2)); g++) begin
                @(negedge clk);
                drive(8'($urandom), 1'b0, 1'($urandom));
            end
        end
        @(negedge clk);
        drive(d, 1'b1, s);
    endtask

    task automatic send_cell(input logic [7:0] h0, h1, h2, h3, h4, input int npay);
        send_byte(h0, 1'b1);
        send_byte(h1, 1'b0);
        send_byte(h2, 1'b0);
        send_byte(h3, 1'b0);
        send_byte(h4, 1'b0);
        for (int k = 0; k < npay; k++) send_byte(8'(k + 1), 1'b0);
    endtask

    typedef struct {
        logic [7:0]  h0, h1, h2, h3, h4;
        logic [3:0]  gfc;
        logic [7:0]  vpi;
        logic [15:0] vci;
        logic [2:0]  pt;
        logic        clp;
        logic        err;
        int          pay_a;
        int          pay_b;
    } vec_t;

    vec_t vecs [5];
    int b_pay [3];
    int b_sop [3];
    int b_eop [3];
    int b_hdr [3];

    task automatic snap();
        for (int d = 0; d < 3; d++) begin
            b_pay[d] = n_pay[d]; b_sop[d] = n_sop[d];
            b_eop[d] = n_eop[d]; b_hdr[d] = n_hdr[d];
        end
    endtask

    initial begin
        vecs[0] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h55, 4'h0, 8'h00, 16'h0000, 3'd0, 1'b0, 1'b0, 48, 48};
        vecs[1] = '{8'h00, 8'h00, 8'h00, 8'h02, 8'h5B, 4'h0, 8'h00, 16'h0000, 3'd1, 1'b0, 1'b0, 48, 48};
        vecs[2] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h54, 4'h0, 8'h00, 16'h0000, 3'd0, 1'b0, 1'b1, 0, 48};
        vecs[3] = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h52, 4'h0, 8'h00, 16'h0000, 3'd0, 1'b1, 1'b0, 0, 0};
        vecs[4] = '{8'h1A, 8'h00, 8'h01, 8'h0F, 8'h96, 4'h1, 8'hA0, 16'h0010, 3'd7, 1'b1, 1'b0, 48, 48};

        drive(8'h00, 1'b0, 1'b0);
        idle(3);
        rst_n = 1'b1;
        idle(2);

        check("reset cnt_good", 32'(cg[0]), 32'd0);
        check("reset cnt_runt", 32'(cr[0]), 32'd0);
        check("reset hdr_valid", 32'(hv[0]), 32'd0);
        check("reset pay_valid", 32'(pv[0]), 32'd0);

        for (int v = 0; v < 5; v++) begin
            snap();
            send_cell(vecs[v].h0, vecs[v].h1, vecs[v].h2, vecs[v].h3, vecs[v].h4, ATM_PAY_BYTES);
            idle(3);
            check($sformatf("v%0d hdr_valid pulses", v), 32'(n_hdr[0] - b_hdr[0]), 32'd1);
            check($sformatf("v%0d gfc", v), 32'(l_gfc), 32'(vecs[v].gfc));
            check($sformatf("v%0d vpi", v), 32'(l_vpi), 32'(vecs[v].vpi));
            check($sformatf("v%0d vci", v), 32'(l_vci), 32'(vecs[v].vci));
            check($sformatf("v%0d pt", v), 32'(l_pt), 32'(vecs[v].pt));
            check($sformatf("v%0d clp", v), 32'(l_clp), 32'(vecs[v].clp));
            check($sformatf("v%0d hec_err", v), 32'(l_hec[0]), 32'(vecs[v].err));
            check($sformatf("v%0d hec_err keep", v), 32'(l_hec[1]), 32'(vecs[v].err));
            check($sformatf("v%0d pay bytes a", v), 32'(n_pay[0] - b_pay[0]), 32'(vecs[v].pay_a));
            check($sformatf("v%0d pay bytes b", v), 32'(n_pay[1] - b_pay[1]), 32'(vecs[v].pay_b));
            check($sformatf("v%0d pay_sop a", v), 32'(n_sop[0] - b_sop[0]), 32'(vecs[v].pay_a / 48));
            check($sformatf("v%0d pay_eop a", v), 32'(n_eop[0] - b_eop[0]), 32'(vecs[v].pay_a / 48));
        end
        check("cnt_good a", 32'(cg[0]), 32'd3);
        check("cnt_err a", 32'(ce[0]), 32'd1);
        check("cnt_idle a", 32'(ci[0]), 32'd1);
        check("cnt_err b", 32'(ce[1]), 32'd1);
        check("cnt_good b", 32'(cg[1]), 32'd3);
        check("cnt_good c", 32'(cg_c), 32'd3);

        // Runt: sop after 20 bytes of a good cell, then a full cell, with valid gaps.
        gap_en = 1'b1;
        snap();
        send_cell(8'h00, 8'h00, 8'h00, 8'h00, 8'h55, 15);
        send_cell(8'h00, 8'h00, 8'h00, 8'h00, 8'h55, ATM_PAY_BYTES);
        idle(3);
        gap_en = 1'b0;
        check("runt cnt_runt a", 32'(cr[0]), 32'd1);
        check("runt cnt_runt c", 32'(cr_c), 32'd1);
        check("runt pay bytes", 32'(n_pay[0] - b_pay[0]), 32'd63);
        check("runt pay_sop", 32'(n_sop[0] - b_sop[0]), 32'd2);
        check("runt pay_eop", 32'(n_eop[0] - b_eop[0]), 32'd1);
        check("runt cnt_good a", 32'(cg[0]), 32'd5);
        check("saturated cnt_good c", 32'(cg_c), 32'd3);
        check("payload data a", 32'(n_bad[0]), 32'd0);
        check("payload data b", 32'(n_bad[1]), 32'd0);
        check("payload data c", 32'(n_bad[2]), 32'd0);

        // Reset in the middle of a forwarded payload.
        send_cell(8'h00, 8'h00, 8'h00, 8'h00, 8'h55, 10);
        @(posedge clk);
        #2;
        check("pre-reset pay_valid", 32'(pv[0]), 32'd1);
        rst_n = 1'b0;
        #1;
        check("async reset pay_valid", 32'(pv[0]), 32'd0);
        check("async reset pay_out", 32'(po[0]), 32'd0);
        check("async reset cnt_good", 32'(cg[0]), 32'd0);
        check("async reset cnt_runt", 32'(cr[0]), 32'd0);
        check("async reset vpi", 32'(vpi[0]), 32'd0);
        check("async reset cnt_good c", 32'(cg_c), 32'd0);
        idle(2);
        rst_n = 1'b1;
        snap();
        for (int k = 10; k < 30; k++) send_byte(8'(k + 1), 1'b0);
        idle(3);
        check("post-reset no payload", 32'(n_pay[0] - b_pay[0]), 32'd0);
        check("post-reset no header", 32'(n_hdr[0] - b_hdr[0]), 32'd0);
        snap();
        send_cell(8'h00, 8'h00, 8'h00, 8'h00, 8'h55, ATM_PAY_BYTES);
        idle(3);
        check("post-reset cell pay", 32'(n_pay[0] - b_pay[0]), 32'd48);
        check("post-reset cell eop", 32'(n_eop[0] - b_eop[0]), 32'd1);
        check("post-reset cnt_good", 32'(cg[0]), 32'd1);
        check("post-reset cnt_runt", 32'(cr[0]), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/atm_header_checker.md
Name: atm_header_checker

Overview:
- Byte-stream stage that receives ATM cells (5-byte UNI header plus 48-byte payload) and consumes the per-byte stream fed to the cell assembler.
- Verifies the header HEC (CRC-8), extracts UNI header fields, drops errored and idle cells, and forwards only the 48 payload bytes of good cells with sop/eop framing.
- Keeps saturating statistics counters for good, errored, idle and runt cells.

Parameters:
- DROP_ERR, 1, when 1 cells with a HEC mismatch are discarded; when 0 they are forwarded with hec_err set.
- DROP_IDLE, 1, when 1 idle cells (header 00 00 00 01) are discarded.
- CNT_W, 16, width of the statistics counters.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- data_in  in  8  cell byte.
- valid_in  in  1  data_in valid this cycle.
- sop_in  in  1  first header byte of a cell; qualified by valid_in.
- gfc  out  4  GFC of the last checked cell.
- vpi  out  8  VPI.
- vci  out  16  VCI.
- pt  out  3  payload type.
- clp  out  1  cell loss priority.
- hdr_valid  out  1  one-cycle pulse; header fields and hec_err are valid.
- hec_err  out  1  HEC mismatch for the current cell; held until the next hdr_valid.
- pay_out  out  8  payload byte.
- pay_valid  out  1  pay_out valid.
- pay_sop  out  1  first payload byte.
- pay_eop  out  1  48th payload byte.
- cnt_good  out  CNT_W  cells forwarded without error.
- cnt_err  out  CNT_W  cells with a HEC mismatch.
- cnt_idle  out  CNT_W  idle cells.
- cnt_runt  out  CNT_W  cells aborted by an early sop_in.

Behaviour:
- Reset: all outputs, counters, the CRC register and the byte counter go to 0. The FSM enters HUNT.
- Only cycles with valid_in=1 advance the FSM. Gaps with valid_in=0 are allowed anywhere and hold all state.
- FSM states:
  - HUNT: wait for sop_in. Bytes without sop_in are ignored.
  - HDR: header bytes 0 to 3.
  - HEC: byte 4.
  - PAY: forward payload bytes 5 to 52.
  - DISC: swallow payload bytes 5 to 52.
- Transitions:
  - HUNT to HDR on valid&sop. That byte is header byte 0.
  - HDR to HEC after byte 3.
  - HEC to PAY or DISC depending on the check result.
  - PAY or DISC to HUNT after byte 52. A 6-bit byte counter runs 0 to 52.
- CRC:
  - Polynomial x^8+x^2+x+1 (0x07), MSB first, initial value 0x00.
  - Computed over header bytes 0 to 3 with a one-byte-per-cycle combinational update.
  - Expected HEC = crc XOR 0x55. On byte 4: hec_err = (data_in != expected).
- Field extraction: header = b0,b1,b2,b3.
  - gfc = b0[7:4]
  - vpi = {b0[3:0], b1[7:4]}
  - vci = {b1[3:0], b2, b3[7:4]}
  - pt = b3[3:1]
  - clp = b3[0]
- Registered outputs: fields, hdr_valid and hec_err are registered. hdr_valid pulses on the clock edge that accepts byte 4.
- Cell classification and counting on byte 4:
  - Idle: b0..b3 = 00 00 00 01 with no HEC error.
  - Error: hec_err=1 increments cnt_err. Goes to DISC if DROP_ERR=1, else to PAY.
  - Idle with no error increments cnt_idle. Goes to DISC if DROP_IDLE=1, else to PAY.
  - Otherwise increments cnt_good and goes to PAY.
- Payload output: one cycle latency from input. pay_out and pay_valid are registered copies of each payload byte. pay_sop is set on byte 5; pay_eop is set on byte 52.
- Early sop_in: valid&sop in any state other than HUNT, before the cell completes, aborts the cell.
  - cnt_runt increments.
  - If payload was being forwarded, no pay_eop is emitted.
  - The byte is treated as header byte 0 of a new cell (state goes to HDR, CRC is reloaded).
  - sop_in on byte 52 itself still counts as an abort.
- Counters saturate at all-ones and do not wrap.
- Mid-operation reset: immediate return to the reset state; no partial output after deassertion.

Decomposition:
- Shared package atm_pkg holds:
  - ATM_CELL_BYTES=53, ATM_HDR_BYTES=5, ATM_PAY_BYTES=48.
  - HEC_POLY=8'h07, HEC_COSET=8'h55.
  - IDLE_HDR=32'h00000001.
  - The FSM state encoding.
- One natural sub-module: atm_hec_crc8, a combinational next-CRC function taking current crc and a data byte.

Test Plan:
- Good cell: header 00 00 00 00 55, payload 01..30 hex.
  - hdr_valid=1, hec_err=0, vpi=0, vci=0.
  - 48 bytes out with pay_sop on 01 and pay_eop on 30.
  - cnt_good=1.
- PT cell: header 00 00 00 02 5B.
  - pt=1, hec_err=0, payload forwarded.
- Errored cell: 00 00 00 00 54.
  - With DROP_ERR=1: hec_err=1, no pay_valid, cnt_err=1.
  - With DROP_ERR=0: 48 payload bytes out with hec_err=1.
- Idle cell: 00 00 00 01 52.
  - cnt_idle=1, no payload out.
  - Then a good cell back-to-back is forwarded.
- Runt: sop_in again after 20 bytes of a good cell, then a full good cell.
  - cnt_runt=1, first cell has no pay_eop, second cell fully forwarded.
  - Valid_in gaps are randomly inserted and do not change the output.
- Saturation and reset: with CNT_W=2, send 5 good cells; cnt_good=3.
  - Assert rst_n=0 mid-payload: all outputs 0 immediately, FSM in HUNT.
